// File: rtl/pam4_tx.sv
// pam4_tx: PAM4 line transmitter. Sends a +3/-3 preamble, then bytes (or PRBS7)
// as Gray-coded symbols, inserting alternating +1/-1 fill symbols when no byte is ready.
// Ports: clk/rst (async active-high), en, prbs_mode, tx_data/tx_valid/tx_ready byte input,
//        DATA/SYM/Sym_en registered line outputs, underrun_cnt saturating fill count.
module pam4_tx #(
  parameter int UI_CLKS = 2,
  parameter int PRE_LEN = 16,
  parameter int LVL_OUT = 96,
  parameter int LVL_IN  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              prbs_mode,
  input  logic [7:0]        tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic signed [7:0] DATA,
  output logic signed [3:0] SYM,
  output logic              Sym_en,
  output logic [7:0]        underrun_cnt
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PRE   = 2'd1;
  localparam logic [1:0] S_XMIT  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic [1:0] state, nstate;
  logic [7:0] ui_cnt;
  logic [7:0] pre_cnt;
  logic [1:0] sym_idx;      // symbols of the current byte already launched (0 = byte boundary)
  logic [7:0] hold;
  logic       full;
  logic [5:0] shift;        // remaining three symbols of the byte in flight
  logic [6:0] lfsr;
  logic       mode_r;       // prbs_mode captured at the byte boundary
  logic       fill_pos;     // polarity of the next fill symbol

  logic              tick, bnd, pay, accept, use_prbs;
  logic [1:0]        prbs_bits;
  logic              launch, do_load, do_fill, adv_lfsr, adv_idx;
  logic signed [3:0] nsym;

  function automatic logic signed [3:0] gray2sym(input logic [1:0] g);
    logic signed [3:0] s;
    case (g)
      2'b00:   s = -4'sd3;
      2'b01:   s = -4'sd1;
      2'b11:   s = 4'sd1;
      default: s = 4'sd3;
    endcase
    return s;
  endfunction

  function automatic logic signed [7:0] sym2lvl(input logic signed [3:0] s);
    logic signed [7:0] l;
    case (s)
      4'sd3:   l = 8'(LVL_OUT);
      4'sd1:   l = 8'(LVL_IN);
      -4'sd1:  l = -8'(LVL_IN);
      -4'sd3:  l = -8'(LVL_OUT);
      default: l = 8'sd0;
    endcase
    return l;
  endfunction

  assign tick      = (state != S_IDLE) && (ui_cnt == 8'(UI_CLKS - 1));
  assign bnd       = (sym_idx == 2'd0);
  assign pay       = (state == S_XMIT) || (state == S_DRAIN);
  assign tx_ready  = (state != S_IDLE) && !full;
  assign accept    = tx_valid && tx_ready;
  // Mode is live only at a boundary; mid-byte the captured value keeps the byte consistent.
  assign use_prbs  = bnd ? prbs_mode : mode_r;
  // Two Fibonacci steps of x^7+x^6+1; the first generated bit is the symbol MSB.
  assign prbs_bits = {lfsr[6] ^ lfsr[5], lfsr[5] ^ lfsr[4]};

  always_comb begin
    nstate = state;
    case (state)
      S_IDLE:  if (en) nstate = S_PRE;
      S_PRE: begin
        if (tick) begin
          if (!en)                                nstate = S_IDLE;
          else if (pre_cnt == 8'(PRE_LEN - 1))    nstate = S_XMIT;
        end
      end
      S_XMIT:  if (!en) nstate = S_DRAIN;
      default: if (tick && bnd) nstate = en ? S_XMIT : S_IDLE;
    endcase
  end

  always_comb begin
    launch   = 1'b0;
    nsym     = 4'sd0;
    do_load  = 1'b0;
    do_fill  = 1'b0;
    adv_lfsr = 1'b0;
    adv_idx  = 1'b0;
    if (tick) begin
      if (state == S_PRE) begin
        if (en) begin
          launch = 1'b1;
          nsym   = pre_cnt[0] ? -4'sd3 : 4'sd3;
        end
      end else if (pay && !(state == S_DRAIN && bnd && !en)) begin
        launch = 1'b1;
        if (use_prbs) begin
          nsym     = gray2sym(prbs_bits);
          adv_lfsr = 1'b1;
          adv_idx  = 1'b1;
        end else if (!bnd) begin
          nsym    = gray2sym(shift[5:4]);
          adv_idx = 1'b1;
        end else if (full) begin
          nsym    = gray2sym(hold[7:6]);
          do_load = 1'b1;
          adv_idx = 1'b1;
        end else begin
          // Fill keeps sym_idx at 0 so the next tick is again a byte boundary.
          nsym    = fill_pos ? 4'sd1 : -4'sd1;
          do_fill = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      ui_cnt       <= '0;
      pre_cnt      <= '0;
      sym_idx      <= '0;
      hold         <= '0;
      full         <= 1'b0;
      shift        <= '0;
      lfsr         <= 7'h7F;
      mode_r       <= 1'b0;
      fill_pos     <= 1'b1;
      DATA         <= '0;
      SYM          <= '0;
      Sym_en       <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      state  <= nstate;
      ui_cnt <= (state == S_IDLE || tick) ? 8'd0 : ui_cnt + 8'd1;
      Sym_en <= launch;

      if (nstate == S_IDLE) begin
        DATA <= '0;
        SYM  <= '0;
      end else if (launch) begin
        DATA <= sym2lvl(nsym);
        SYM  <= nsym;
      end

      if (state != S_PRE) pre_cnt <= '0;
      else if (launch)    pre_cnt <= pre_cnt + 8'd1;

      if (nstate == S_IDLE) sym_idx <= '0;
      else if (adv_idx)     sym_idx <= sym_idx + 2'd1;

      if (launch && bnd && pay) mode_r <= prbs_mode;

      if (do_load)                    shift <= hold[5:0];
      else if (adv_idx && !use_prbs)  shift <= {shift[3:0], 2'b00};

      if (adv_lfsr) lfsr <= {lfsr[4:0], prbs_bits};

      // A pending byte does not survive the return to IDLE.
      if (nstate == S_IDLE) begin
        full <= 1'b0;
      end else if (accept) begin
        hold <= tx_data;
        full <= 1'b1;
      end else if (do_load) begin
        full <= 1'b0;
      end

      if (do_fill)                         fill_pos <= ~fill_pos;
      else if (launch || state == S_IDLE)  fill_pos <= 1'b1;

      if (do_fill && underrun_cnt != 8'hFF) underrun_cnt <= underrun_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_pam4_tx.sv
// tb_pam4_tx: directed bench for pam4_tx with a queue of expected line symbols.
// Stimulus phases push the symbols they must cause; one compare process pops on every Sym_en.
`timescale 1ns/1ps
module tb_pam4_tx;
  localparam int UI  = 2;
  localparam int PRE = 4;
  localparam int LO  = 96;
  localparam int LI  = 32;
  localparam int NPRBS = 132;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              en = 1'b0;
  logic              prbs_mode = 1'b0;
  logic [7:0]        tx_data = 8'h00;
  logic              tx_valid = 1'b0;
  logic              tx_ready;
  logic signed [7:0] DATA;
  logic signed [3:0] SYM;
  logic              Sym_en;
  logic [7:0]        underrun_cnt;

  pam4_tx #(.UI_CLKS(UI), .PRE_LEN(PRE), .LVL_OUT(LO), .LVL_IN(LI)) dut (
    .clk(clk), .rst(rst), .en(en), .prbs_mode(prbs_mode),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .DATA(DATA), .SYM(SYM), .Sym_en(Sym_en), .underrun_cnt(underrun_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int exp_q[$];
  int cyc = 0;
  int prev_cyc = -1;
  bit gap_on = 1'b0;
  int gray_tab[4] = '{-3, -1, 3, 1};   // indexed by the 2-bit Gray code
  int psym[NPRBS];
  bit pb[$];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int lvl(input int s);
    case (s)
      3:       return LO;
      1:       return LI;
      -1:      return -LI;
      -3:      return -LO;
      default: return 0;
    endcase
  endfunction

  task automatic push_pre();
    for (int i = 0; i < PRE; i++) exp_q.push_back((i % 2 == 0) ? 3 : -3);
  endtask

  task automatic push_byte(input logic [7:0] b);
    logic [1:0] c;
    for (int i = 3; i >= 0; i--) begin
      c = b[2*i+1 -: 2];
      exp_q.push_back(gray_tab[c]);
    end
  endtask

  task automatic push_fill(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back((i % 2 == 0) ? 1 : -1);
  endtask

  task automatic start_phase();
    prev_cyc = -1;
    gap_on   = 1'b1;
  endtask

  // Returns just after the posedge that launches the symbol leaving k expectations queued.
  task automatic wait_left(input string name, input int k, input int bound);
    for (int n = 0; n < bound; n++) begin
      @(posedge clk); #1;
      if (Sym_en && exp_q.size() == k) return;
    end
    total++;
    bad++;
    $display("FAIL %s: timeout, got %0d symbols outstanding required %0d", name, exp_q.size(), k);
    exp_q.delete();
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    tx_data  = b;
    tx_valid = 1'b1;
    for (n = 0; n < 100; n++) begin
      @(negedge clk);
      if (tx_ready) break;
    end
    if (n == 100) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: tx_ready never rose for byte %02h", b);
    end
    @(posedge clk); #1;
    chk("ready_low_while_full", int'(tx_ready), 0);
  endtask

  task automatic idle_chk(input string name);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk({name, "_data"}, int'(DATA), 0);
    chk({name, "_sym"}, int'(SYM), 0);
    chk({name, "_ready"}, int'(tx_ready), 0);
    chk({name, "_pending"}, exp_q.size(), 0);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst && Sym_en) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL extra_sym: got SYM=%0d with no symbol required (cycle %0d)", SYM, cyc);
      end else begin
        int e;
        e = exp_q.pop_front();
        chk("sym", int'(SYM), e);
        chk("data", int'(DATA), lvl(e));
      end
      if (gap_on && prev_cyc >= 0) chk("sym_gap", cyc - prev_cyc, UI);
      prev_cyc = cyc;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_data", int'(DATA), 0);
    chk("rst_sym", int'(SYM), 0);
    chk("rst_sym_en", int'(Sym_en), 0);
    chk("rst_ready", int'(tx_ready), 0);
    chk("rst_underrun", int'(underrun_cnt), 0);

    // Preamble +3,-3,+3,-3 then byte 00_01_11_10 -> -3,-1,+1,+3
    start_phase();
    push_pre();
    exp_q.push_back(-3); exp_q.push_back(-1); exp_q.push_back(1); exp_q.push_back(3);
    en = 1'b1;
    send_byte(8'b00_01_11_10);
    tx_valid = 1'b0;
    wait_left("byte_1e", 1, 100);
    en = 1'b0; gap_on = 1'b0;
    idle_chk("drain_idle");

    // Back-to-back bytes with tx_valid held high: no gaps, no fill
    start_phase();
    push_pre(); push_byte(8'hA5); push_byte(8'h3C);
    en = 1'b1;
    send_byte(8'hA5);
    send_byte(8'h3C);
    tx_valid = 1'b0;
    wait_left("bytes_a5_3c", 1, 200);
    en = 1'b0; gap_on = 1'b0;
    idle_chk("b2b_idle");
    chk("b2b_underrun", int'(underrun_cnt), 0);

    // Three empty boundaries -> +1,-1,+1
    start_phase();
    push_pre(); push_fill(3);
    en = 1'b1;
    wait_left("fill3", 1, 100);
    en = 1'b0; gap_on = 1'b0;
    idle_chk("fill3_idle");
    chk("underrun_3", int'(underrun_cnt), 3);

    // en dropped during the preamble stops at the next tick
    start_phase();
    exp_q.push_back(3); exp_q.push_back(-3);
    en = 1'b1;
    wait_left("pre_abort", 1, 50);
    en = 1'b0; gap_on = 1'b0;
    idle_chk("pre_abort_idle");

    // 300 more empty boundaries saturate the counter
    start_phase();
    push_pre(); push_fill(300);
    en = 1'b1;
    wait_left("fill300", 1, 2000);
    en = 1'b0; gap_on = 1'b0;
    idle_chk("fill300_idle");
    chk("underrun_sat", int'(underrun_cnt), 255);

    // Reset pulse in the middle of a byte
    start_phase();
    push_pre(); push_byte(8'h1E);
    en = 1'b1;
    send_byte(8'h1E);
    tx_valid = 1'b0;
    wait_left("mid_byte", 3, 100);
    #2 rst = 1'b1;
    #1;
    chk("arst_data", int'(DATA), 0);
    chk("arst_sym", int'(SYM), 0);
    chk("arst_sym_en", int'(Sym_en), 0);
    chk("arst_ready", int'(tx_ready), 0);
    chk("arst_underrun", int'(underrun_cnt), 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    chk("in_rst_sym_en", int'(Sym_en), 0);
    @(posedge clk); #1 rst = 1'b0;
    start_phase();
    push_pre(); push_fill(1);
    wait_left("restart", 1, 100);
    en = 1'b0; gap_on = 1'b0;
    idle_chk("restart_idle");
    chk("underrun_after_rst", int'(underrun_cnt), 1);

    // PRBS7 reference: b[n] = b[n-7] ^ b[n-6], seven seed ones, two bits per symbol MSB first
    for (int i = 0; i < 7; i++) pb.push_back(1'b1);
    for (int i = 0; i < 2 * NPRBS; i++) pb.push_back(pb[pb.size()-7] ^ pb[pb.size()-6]);
    for (int j = 0; j < NPRBS; j++) begin
      logic [1:0] c;
      c = {pb[7 + 2*j], pb[8 + 2*j]};
      psym[j] = gray_tab[c];
    end
    chk("prbs_model_s0", psym[0], -3);
    chk("prbs_model_s1", psym[1], -3);
    chk("prbs_model_s2", psym[2], -3);
    chk("prbs_model_s3", psym[3], 3);
    chk("prbs_model_period0", psym[127], psym[0]);
    chk("prbs_model_period3", psym[130], psym[3]);

    prbs_mode = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    start_phase();
    push_pre();
    for (int j = 0; j < NPRBS; j++) exp_q.push_back(psym[j]);
    en = 1'b1;
    wait_left("prbs", 1, 600);
    en = 1'b0; gap_on = 1'b0;
    idle_chk("prbs_idle");
    chk("prbs_underrun", int'(underrun_cnt), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pam4_tx.md
PAM4_TX -- requirements
Module: pam4_tx

Interface
REQ-001 Parameter UI_CLKS, default 2: clk cycles per symbol (UI), legal range 2..255.
REQ-002 Parameter PRE_LEN, default 16: preamble length in symbols, legal range 1..255.
REQ-003 Parameter LVL_OUT, default 96: magnitude of the outer level for symbols ±3.
REQ-004 Parameter LVL_IN, default 32: magnitude of the inner level for symbols ±1.
REQ-005 Ports SHALL be as follows; clock is clk, reset is rst, one clock, reset asynchronous and active-high:
- clk  in  1  system clock, all logic on posedge
- rst  in  1  asynchronous active-high reset
- en  in  1  transmitter enable
- prbs_mode  in  1  1 = PRBS7 symbol source, 0 = byte input
- tx_data  in  8  byte to transmit
- tx_valid  in  1  tx_data valid
- tx_ready  out  1  holding register empty, byte will be accepted
- DATA  out  8 signed  PAM4 line level
- SYM  out  4 signed  current symbol (-3, -1, +1, +3; 0 when idle)
- Sym_en  out  1  1-cycle pulse in the cycle DATA/SYM take a new symbol
- underrun_cnt  out  8  saturating count of fill symbols sent

Function
REQ-006 UI counter SHALL count 0..UI_CLKS-1 and wrap; tick = (count == UI_CLKS-1); counter held at 0 in IDLE.
REQ-007 DATA, SYM and Sym_en SHALL be registered; on each tick outside IDLE, DATA/SYM load the next symbol and Sym_en is 1 in the following cycle only.
REQ-008 Gray mapping SHALL be: 2'b00 -> -3, 2'b01 -> -1, 2'b11 -> +1, 2'b10 -> +3.
REQ-009 Level mapping SHALL be: ±3 -> ±LVL_OUT, ±1 -> ±LVL_IN, two's complement.
REQ-010 FSM states SHALL be IDLE, PREAMBLE, XMIT, DRAIN.
REQ-011 IDLE -> PREAMBLE when en=1; DATA=0, SYM=0 in IDLE.
REQ-012 PREAMBLE SHALL send PRE_LEN symbols alternating +3, -3, starting with +3, then enter XMIT.
REQ-013 XMIT, byte mode: each byte SHALL be sent as 4 symbols, bits [7:6] first and [1:0] last.
REQ-014 At a byte boundary, a full holding register SHALL load the shifter in the same cycle as the tick that launches the byte's first symbol.
REQ-015 At a byte boundary with the holding register empty, one fill symbol SHALL be sent instead, alternating +1, -1 starting with +1 on each underrun run, and underrun_cnt incremented, saturating at 255.
REQ-016 Holding register SHALL be one entry; tx_ready = !full; accept on tx_valid && tx_ready; accept and shifter load in the same cycle are permitted; tx_ready=0 in IDLE.
REQ-017 XMIT, prbs_mode=1: PRBS7 x^7+x^6+1 seeded 7'h7F, advanced 2 bits per symbol, first bit as MSB; byte input ignored, holding register retained.
REQ-018 prbs_mode SHALL be sampled only at byte boundaries; a change mid-byte takes effect at the next boundary.
REQ-019 en=0 in PREAMBLE SHALL go to IDLE at the next tick.
REQ-020 en=0 in XMIT SHALL enter DRAIN, finish the current byte, then go IDLE; a byte pending in the holding register is discarded.
REQ-021 en=1 in DRAIN SHALL return to XMIT at the byte boundary without a new preamble.
REQ-022 Latency SHALL be: byte accepted while XMIT and the shifter is at its last symbol -> its first symbol on DATA at most 1 UI + 1 cycle later.

Reset
REQ-023 Asynchronous rst=1 SHALL force: FSM=IDLE, UI counter=0, holding register empty, LFSR=7'h7F, DATA=0, SYM=0, Sym_en=0, tx_ready=0, underrun_cnt=0.
REQ-024 rst asserted mid-byte or mid-preamble SHALL abort immediately with no further Sym_en pulse; after release, operation restarts from IDLE/preamble.

Verification
REQ-025 Bench: en=1, UI_CLKS=2, PRE_LEN=4 -> DATA = +96, -96, +96, -96 with Sym_en every 2 cycles, then XMIT.
REQ-026 Bench: byte 8'b00_01_11_10 -> SYM -3, -1, +1, +3 and DATA -96, -32, +32, +96, each held 2 cycles.
REQ-027 Bench: tx_valid held high with bytes 0xA5, 0x3C -> no gaps, no fill symbols, tx_ready low while holding full, underrun_cnt=0.
REQ-028 Bench: no bytes for 3 boundaries -> SYM +1, -1, +1 and underrun_cnt=3; with 300 boundaries -> underrun_cnt=255.
REQ-029 Bench: prbs_mode=1 from reset -> first 4 symbols match a reference PRBS7 (seed 7'h7F) Gray-mapped model; sequence period is 127 symbols.
REQ-030 Bench: rst pulse mid-byte -> all outputs 0 asynchronously; with en=1 after release, the preamble restarts with +96.
